// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback port arbiter (ALU > LSU/DIV with anti-starvation) plus pending-write scoreboard.
module wb_arbiter #(
  parameter int REG_NUM    = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_we_i,
  input  logic [ADDR_W-1:0]  alu_waddr_i,
  input  logic [DATA_W-1:0]  alu_wdata_i,
  input  logic               lsu_valid_i,
  input  logic [ADDR_W-1:0]  lsu_waddr_i,
  input  logic [DATA_W-1:0]  lsu_wdata_i,
  output logic               lsu_ready_o,
  input  logic               div_valid_i,
  input  logic [ADDR_W-1:0]  div_waddr_i,
  input  logic [DATA_W-1:0]  div_wdata_i,
  output logic               div_ready_o,
  input  logic               issue_en_i,
  input  logic [ADDR_W-1:0]  issue_addr_i,
  output logic               w_en_o,
  output logic [ADDR_W-1:0]  w_addr_o,
  output logic [DATA_W-1:0]  w_data_o,
  output logic [REG_NUM-1:0] busy_o
);
  localparam int SW = STARVE_MAX > 0 ? $clog2(STARVE_MAX + 1) : 1;
  logic [SW-1:0]      starve_q, starve_d;
  logic               w_en_q, w_en_d;
  logic [ADDR_W-1:0]  w_addr_q, w_addr_d, g_addr;
  logic [DATA_W-1:0]  w_data_q, w_data_d, g_data;
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               div_pri, gnt;
  always_comb begin
    div_pri     = starve_q == SW'(STARVE_MAX);
    lsu_ready_o = rst_n & lsu_valid_i & ~alu_we_i & ~(div_pri & div_valid_i);
    div_ready_o = rst_n & div_valid_i & ~alu_we_i & ~(~div_pri & lsu_valid_i);
    gnt         = alu_we_i | lsu_ready_o | div_ready_o;
    g_addr      = alu_we_i ? alu_waddr_i : lsu_ready_o ? lsu_waddr_i : div_waddr_i;
    g_data      = alu_we_i ? alu_wdata_i : lsu_ready_o ? lsu_wdata_i : div_wdata_i;
    w_en_d      = gnt & (g_addr != '0);
    w_addr_d    = gnt ? g_addr : w_addr_q;
    w_data_d    = gnt ? g_data : w_data_q;
    starve_d    = (div_valid_i & ~div_ready_o) ? (div_pri ? starve_q : starve_q + 1'b1) : '0;
    busy_d      = busy_q;
    if (lsu_ready_o) busy_d[lsu_waddr_i] = 1'b0;
    if (div_ready_o) busy_d[div_waddr_i] = 1'b0;
    if (issue_en_i) busy_d[issue_addr_i] = 1'b1;
    busy_d[0]   = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      busy_q   <= '0;
    end else begin
      starve_q <= starve_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      busy_q   <= busy_d;
    end
  end
  assign w_en_o   = w_en_q;
  assign w_addr_o = w_addr_q;
  assign w_data_o = w_data_q;
  assign busy_o   = busy_q;
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
- REQ-001 SHALL have parameter REG_NUM, default 32: number of architectural registers.
- REQ-002 SHALL have parameter ADDR_W, default 5: register address width.
- REQ-003 SHALL have parameter DATA_W, default 32: register data width.
- REQ-004 SHALL have parameter STARVE_MAX, default 4: consecutive DIV-stall cycles before DIV outranks LSU.
- REQ-005 SHALL have ports, with the clock and reset first:
  - clk  in  1  clock.
  - rst_n  in  1  reset, asynchronous, active-low.
  - alu_we_i  in  1  single-cycle ALU writeback request; cannot be stalled.
  - alu_waddr_i  in  ADDR_W  ALU destination register.
  - alu_wdata_i  in  DATA_W  ALU result.
  - lsu_valid_i  in  1  load result valid.
  - lsu_waddr_i  in  ADDR_W  load destination register.
  - lsu_wdata_i  in  DATA_W  load data.
  - lsu_ready_o  out  1  load result accepted this cycle.
  - div_valid_i  in  1  divider result valid.
  - div_waddr_i  in  ADDR_W  divider destination register.
  - div_wdata_i  in  DATA_W  divider result.
  - div_ready_o  out  1  divider result accepted this cycle.
  - issue_en_i  in  1  a long-latency (LSU/DIV) op issued this cycle.
  - issue_addr_i  in  ADDR_W  destination of the issued op.
  - w_en_o  out  1  regfile write enable.
  - w_addr_o  out  ADDR_W  regfile write address.
  - w_data_o  out  DATA_W  regfile write data.
  - busy_o  out  REG_NUM  pending long-latency write bitmap.

Function
- REQ-006 SHALL grant at most one source per cycle, with ALU always highest priority.
- REQ-007 SHALL rank LSU above DIV, except when starve_cnt == STARVE_MAX, in which case DIV SHALL rank above LSU.
- REQ-008 SHALL drive the ready outputs combinationally from the same-cycle inputs and state:
  - lsu_ready_o = lsu_valid_i & ~alu_we_i & ~(div priority & div_valid_i).
  - div_ready_o = the same rule, mirrored for DIV.
- REQ-009 SHALL complete a handshake on the rising clk edge where valid & ready are both 1; the source then either holds or changes its payload.
- REQ-010 SHALL register the granted write so that w_en_o/w_addr_o/w_data_o appear exactly 1 cycle after the grant cycle.
- REQ-011 SHALL drive w_en_o=0 and leave w_addr_o/w_data_o holding their last values when nothing is granted.
- REQ-012 SHALL accept a granted write whose address is 0 (ready asserted, busy unaffected) but SHALL force w_en_o=0 for it.
- REQ-013 SHALL maintain starve_cnt with width clog2(STARVE_MAX+1):
  - increment when div_valid_i=1 and div_ready_o=0;
  - saturate at STARVE_MAX;
  - clear on a DIV grant or when div_valid_i=0.
- REQ-014 SHALL set busy bit issue_addr_i on the edge where issue_en_i=1, except for address 0.
- REQ-015 SHALL clear busy bit a on the edge where an LSU or DIV grant to address a occurs.
- REQ-016 SHALL keep the busy bit set when a set and a clear to the same address occur on the same edge (set wins).
- REQ-017 SHALL never clear busy bits on an ALU write.
- REQ-018 SHALL hold busy_o[0] at 0 permanently.
- REQ-019 SHALL NOT let busy_o reflect same-cycle issue or grant; busy_o is registered state only.
- REQ-020 SHALL implement no internal buffering: a non-granted source holds its valid and payload until accepted.

Reset
- REQ-021 SHALL, on rst_n=0 and at any time including mid-handshake, asynchronously clear w_en_o, w_addr_o, w_data_o, busy_o and starve_cnt to 0.
- REQ-022 SHALL drive lsu_ready_o and div_ready_o to 0 while rst_n=0.
- REQ-023 SHALL take its first grant on the first clk edge after rst_n deasserts.

Verification
- REQ-024 SHALL be verified with ALU only: alu_we_i=1, addr=5, data=0xDEADBEEF -> next cycle w_en_o=1, w_addr_o=5, w_data_o=0xDEADBEEF.
- REQ-025 SHALL be verified with ALU, LSU and DIV all valid in one cycle (ALU addr 3; LSU addr 7, data 0x11; DIV addr 9):
  - cycle 1: ALU written, both readys 0;
  - cycle 2: LSU granted, written next cycle;
  - cycle 3: DIV granted.
- REQ-026 SHALL be verified for starvation with STARVE_MAX=4: DIV valid and LSU valid continuously with new payloads every cycle, no ALU -> LSU granted 4 cycles, DIV granted on cycle 5, starve_cnt returns to 0.
- REQ-027 SHALL be verified for the scoreboard:
  - issue addr 12 -> busy_o[12]=1 next cycle;
  - LSU grant to 12 concurrent with a new issue to 12 -> busy_o[12] stays 1;
  - a later grant alone -> busy_o[12]=0;
  - issue to addr 0 -> busy_o stays 0.
- REQ-028 SHALL be verified for x0: LSU valid, addr 0 -> lsu_ready_o=1 and w_en_o stays 0.
- REQ-029 SHALL be verified for reset mid-operation: assert rst_n=0 with busy_o=0x0000_1080 and starve_cnt=3 -> all outputs 0 immediately, without waiting for a clk edge.
